jtframe_ddram_avl: RTL and testbench

JTFRAME_DDRAM_AVL -- requirements
Module: jtframe_ddram_avl

---
 rtl/jtframe_ddram_pkg.sv | 15 +
 rtl/jtframe_ddram_avl.sv | 150 +++++++++++++++
 tb/tb_jtframe_ddram_avl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/jtframe_ddram_pkg.sv
// rtl/jtframe_ddram_pkg.sv - shared state encoding and default widths for the DDRAM Avalon bridge
package jtframe_ddram_pkg;

  localparam int DEF_AW = 26;
  localparam int DEF_BW = 8;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    RD_REQ,
    RD_DATA,
    WR
  } state_t;

endpackage

// File: rtl/jtframe_ddram_avl.sv
// rtl/jtframe_ddram_avl.sv - line-frame buffer DDRAM port to Avalon-MM burst bridge
//
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   ddram_*             frame-buffer side: requests, write data, stall, read data and beat strobe
//   local_init_done     controller calibration complete
//   avl_*               Avalon-MM burst master towards the DDR3 controller
module jtframe_ddram_avl
  import jtframe_ddram_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int BW = DEF_BW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [28:0]   ddram_addr,
  input  logic [BW-1:0] ddram_burstcnt,
  input  logic          ddram_rd,
  input  logic          ddram_we,
  input  logic [63:0]   ddram_din,
  input  logic [7:0]    ddram_be,
  output logic          ddram_busy,
  output logic [63:0]   ddram_dout,
  output logic          ddram_dout_ready,
  input  logic          local_init_done,
  input  logic          avl_ready,
  input  logic          avl_rdata_valid,
  input  logic [63:0]   avl_rdata,
  output logic [AW-1:0] avl_addr,
  output logic [BW-1:0] avl_size,
  output logic          avl_read_req,
  output logic          avl_write_req,
  output logic          avl_burstbegin,
  output logic [63:0]   avl_wdata,
  output logic [7:0]    avl_be
);

  state_t        state, state_nxt;
  logic [BW-1:0] remain;      // beats still owed in the current burst
  logic [BW-1:0] size_eff;
  logic          busy;
  logic          rd_start, wr_start, rd_beat, rd_last, wr_accept, wr_last, wr_load;

  // Upper address bits of the frame-buffer word address are outside the DDR window.
  logic unused_addr;
  assign unused_addr = ^ddram_addr[28:AW];

  // A zero burst count still moves one word.
  assign size_eff = (ddram_burstcnt == '0) ? BW'(1) : ddram_burstcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    rd_start  = 1'b0;
    wr_start  = 1'b0;
    rd_beat   = 1'b0;
    rd_last   = 1'b0;
    wr_accept = 1'b0;
    wr_last   = 1'b0;
    wr_load   = 1'b0;
    case (state)
      INIT: begin
        if (local_init_done) state_nxt = IDLE;
      end
      IDLE: begin
        busy = ~local_init_done;
        if (!local_init_done) begin
          state_nxt = INIT;
        end else if (ddram_rd) begin
          // read has priority; a simultaneous write strobe is dropped
          rd_start  = 1'b1;
          state_nxt = RD_REQ;
        end else if (ddram_we) begin
          wr_start  = 1'b1;
          state_nxt = WR;
        end
      end
      RD_REQ, RD_DATA: begin
        // the controller may return beats before we see our own ready edge
        rd_beat = avl_rdata_valid;
        rd_last = avl_rdata_valid && (remain == BW'(1));
        if (rd_last)                         state_nxt = IDLE;
        else if (state == RD_REQ && avl_ready) state_nxt = RD_DATA;
      end
      WR: begin
        // avl_write_req doubles as the "beat pending" flag
        busy      = avl_write_req & ~avl_ready;
        wr_accept = avl_write_req & avl_ready;
        wr_last   = wr_accept && (remain == BW'(1));
        wr_load   = ddram_we & ~busy & ~wr_last;
        if (wr_last) state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

  assign ddram_busy = busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remain           <= '0;
      avl_addr         <= '0;
      avl_size         <= '0;
      avl_read_req     <= 1'b0;
      avl_write_req    <= 1'b0;
      avl_burstbegin   <= 1'b0;
      avl_wdata        <= '0;
      avl_be           <= '0;
      ddram_dout       <= '0;
      ddram_dout_ready <= 1'b0;
    end else begin
      avl_burstbegin   <= 1'b0;
      ddram_dout_ready <= 1'b0;
      if (rd_start || wr_start) begin
        avl_addr       <= ddram_addr[AW-1:0];
        avl_size       <= size_eff;
        remain         <= size_eff;
        avl_burstbegin <= 1'b1;
      end
      if (rd_start) avl_read_req <= 1'b1;
      if (wr_start) begin
        avl_write_req <= 1'b1;
        avl_wdata     <= ddram_din;
        avl_be        <= ddram_be;
      end
      if ((state == RD_REQ && avl_ready) || rd_last) avl_read_req <= 1'b0;
      if (rd_beat) begin
        ddram_dout       <= avl_rdata;
        ddram_dout_ready <= 1'b1;
        remain           <= remain - BW'(1);
      end
      if (wr_accept) begin
        remain        <= remain - BW'(1);
        avl_write_req <= 1'b0;
      end
      // a beat offered in the same cycle as an acceptance keeps the bus busy
      if (wr_load) begin
        avl_wdata     <= ddram_din;
        avl_be        <= ddram_be;
        avl_write_req <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jtframe_ddram_avl.sv
// tb/tb_jtframe_ddram_avl.sv - directed self-checking bench for jtframe_ddram_avl
module tb_jtframe_ddram_avl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [28:0] ddram_addr;
  logic [7:0]  ddram_burstcnt;
  logic        ddram_rd, ddram_we;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic        ddram_busy;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;
  logic        local_init_done;
  logic        avl_ready, avl_rdata_valid;
  logic [63:0] avl_rdata;
  logic [25:0] avl_addr;
  logic [7:0]  avl_size;
  logic        avl_read_req, avl_write_req, avl_burstbegin;
  logic [63:0] avl_wdata;
  logic [7:0]  avl_be;

  int tests = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtframe_ddram_avl dut (
    .clk(clk), .rst_n(rst_n),
    .ddram_addr(ddram_addr), .ddram_burstcnt(ddram_burstcnt),
    .ddram_rd(ddram_rd), .ddram_we(ddram_we),
    .ddram_din(ddram_din), .ddram_be(ddram_be),
    .ddram_busy(ddram_busy), .ddram_dout(ddram_dout), .ddram_dout_ready(ddram_dout_ready),
    .local_init_done(local_init_done),
    .avl_ready(avl_ready), .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata),
    .avl_addr(avl_addr), .avl_size(avl_size),
    .avl_read_req(avl_read_req), .avl_write_req(avl_write_req), .avl_burstbegin(avl_burstbegin),
    .avl_wdata(avl_wdata), .avl_be(avl_be)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; local_init_done = 1'b0;
    ddram_addr = '0; ddram_burstcnt = '0; ddram_rd = 1'b0; ddram_we = 1'b0;
    ddram_din = '0; ddram_be = '0; avl_ready = 1'b0; avl_rdata_valid = 1'b0; avl_rdata = '0;
    step(); step();
    tests++; if (ddram_busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b exp 1", ddram_busy); end
    tests++; if ({avl_read_req, avl_write_req, avl_burstbegin, ddram_dout_ready} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes got %b exp 0000", {avl_read_req, avl_write_req, avl_burstbegin, ddram_dout_ready}); end
    tests++; if ({avl_addr, avl_size, avl_wdata, avl_be, ddram_dout} !== '0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {avl_addr, avl_size, avl_wdata, avl_be, ddram_dout}); end
    rst_n = 1'b1;
  endtask

  task automatic test_init();
    int bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (ddram_busy !== 1'b1) bad++;
    end
    tests++; if (bad != 0) begin errors++; $display("FAIL init_busy_hold got %0d low cycles exp 0", bad); end
    local_init_done = 1'b1;
    #1;
    tests++; if (ddram_busy !== 1'b1) begin errors++; $display("FAIL init_busy_edge got %b exp 1", ddram_busy); end
    step();
    tests++; if (ddram_busy !== 1'b0) begin errors++; $display("FAIL init_idle_busy got %b exp 0", ddram_busy); end
  endtask

  task automatic test_read();
    ddram_rd = 1'b1; ddram_addr = 29'h123; ddram_burstcnt = 8'd4;
    step();
    ddram_rd = 1'b0; avl_ready = 1'b0;
    tests++; if (avl_read_req !== 1'b1) begin errors++; $display("FAIL rd_req got %b exp 1", avl_read_req); end
    tests++; if (avl_burstbegin !== 1'b1) begin errors++; $display("FAIL rd_burstbegin got %b exp 1", avl_burstbegin); end
    tests++; if (avl_addr !== 26'h123) begin errors++; $display("FAIL rd_addr got %h exp 123", avl_addr); end
    tests++; if (avl_size !== 8'd4) begin errors++; $display("FAIL rd_size got %0d exp 4", avl_size); end
    tests++; if (ddram_busy !== 1'b1) begin errors++; $display("FAIL rd_busy got %b exp 1", ddram_busy); end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if ({avl_read_req, avl_burstbegin, avl_addr} !== {2'b10, 26'h123}) begin
        errors++; $display("FAIL rd_stall%0d got req=%b bb=%b addr=%h exp req=1 bb=0 addr=123", i, avl_read_req, avl_burstbegin, avl_addr); end
    end
    avl_ready = 1'b1;
    step();
    avl_ready = 1'b0;
    tests++; if (avl_read_req !== 1'b0) begin errors++; $display("FAIL rd_req_drop got %b exp 0", avl_read_req); end
    for (int i = 0; i < 4; i++) begin
      avl_rdata_valid = 1'b1; avl_rdata = 64'hA + 64'(i);
      step();
      tests++; if (ddram_dout_ready !== 1'b1 || ddram_dout !== 64'hA + 64'(i)) begin
        errors++; $display("FAIL rd_beat%0d got rdy=%b data=%h exp rdy=1 data=%h", i, ddram_dout_ready, ddram_dout, 64'hA + 64'(i)); end
    end
    avl_rdata_valid = 1'b0;
    tests++; if (ddram_busy !== 1'b0) begin errors++; $display("FAIL rd_idle got busy=%b exp 0", ddram_busy); end
    avl_rdata_valid = 1'b1; avl_rdata = 64'hEE;
    step();
    avl_rdata_valid = 1'b0;
    tests++; if (ddram_dout_ready !== 1'b0) begin errors++; $display("FAIL rd_excess got %b exp 0", ddram_dout_ready); end
  endtask

  task automatic test_write();
    ddram_we = 1'b1; ddram_addr = 29'h40; ddram_burstcnt = 8'd3; ddram_din = 64'hD1; ddram_be = 8'hF0;
    #1;
    tests++; if (ddram_busy !== 1'b0) begin errors++; $display("FAIL wr_idle_busy got %b exp 0", ddram_busy); end
    step();
    ddram_din = 64'hD2; ddram_be = 8'h0F; ddram_addr = 29'h999; avl_ready = 1'b0;
    tests++; if ({avl_write_req, avl_burstbegin, avl_wdata, avl_be} !== {2'b11, 64'hD1, 8'hF0}) begin
      errors++; $display("FAIL wr_beat1 got req=%b bb=%b data=%h be=%h exp 1 1 d1 f0", avl_write_req, avl_burstbegin, avl_wdata, avl_be); end
    tests++; if (avl_addr !== 26'h40 || avl_size !== 8'd3) begin
      errors++; $display("FAIL wr_cmd got addr=%h size=%0d exp 40 3", avl_addr, avl_size); end
    #1;
    tests++; if (ddram_busy !== 1'b1) begin errors++; $display("FAIL wr_stall_busy got %b exp 1", ddram_busy); end
    step();
    tests++; if (avl_wdata !== 64'hD1 || avl_burstbegin !== 1'b0) begin
      errors++; $display("FAIL wr_hold1 got data=%h bb=%b exp d1 0", avl_wdata, avl_burstbegin); end
    avl_ready = 1'b1;
    #1;
    tests++; if (ddram_busy !== 1'b0) begin errors++; $display("FAIL wr_pass_busy got %b exp 0", ddram_busy); end
    step();
    avl_ready = 1'b0; ddram_din = 64'hD3; ddram_be = 8'h33;
    tests++; if (avl_wdata !== 64'hD2 || avl_be !== 8'h0F) begin
      errors++; $display("FAIL wr_beat2 got data=%h be=%h exp d2 0f", avl_wdata, avl_be); end
    step();
    tests++; if (avl_wdata !== 64'hD2) begin errors++; $display("FAIL wr_hold2 got %h exp d2", avl_wdata); end
    avl_ready = 1'b1;
    step();
    ddram_we = 1'b0; avl_ready = 1'b0;
    tests++; if (avl_wdata !== 64'hD3 || avl_be !== 8'h33 || avl_write_req !== 1'b1) begin
      errors++; $display("FAIL wr_beat3 got data=%h be=%h req=%b exp d3 33 1", avl_wdata, avl_be, avl_write_req); end
    step();
    avl_ready = 1'b1;
    step();
    avl_ready = 1'b0;
    tests++; if (avl_write_req !== 1'b0 || ddram_busy !== 1'b0) begin
      errors++; $display("FAIL wr_done got req=%b busy=%b exp 0 0", avl_write_req, ddram_busy); end
    tests++; if (avl_addr !== 26'h40) begin errors++; $display("FAIL wr_addr_keep got %h exp 40", avl_addr); end
    step();
    tests++; if (avl_write_req !== 1'b0) begin errors++; $display("FAIL wr_after got %b exp 0", avl_write_req); end
  endtask

  task automatic test_rd_we();
    int bad = 0;
    ddram_rd = 1'b1; ddram_we = 1'b1; ddram_addr = 29'h55; ddram_burstcnt = 8'd2; ddram_din = 64'hBAD;
    step();
    ddram_rd = 1'b0; ddram_we = 1'b0;
    tests++; if (avl_read_req !== 1'b1 || avl_write_req !== 1'b0) begin
      errors++; $display("FAIL rdwe_cmd got rd=%b wr=%b exp 1 0", avl_read_req, avl_write_req); end
    avl_ready = 1'b1;
    step();
    avl_ready = 1'b0;
    if (avl_write_req !== 1'b0) bad++;
    for (int i = 0; i < 2; i++) begin
      avl_rdata_valid = 1'b1; avl_rdata = 64'h100 + 64'(i);
      step();
      if (avl_write_req !== 1'b0) bad++;
    end
    avl_rdata_valid = 1'b0;
    step();
    if (avl_write_req !== 1'b0) bad++;
    tests++; if (bad != 0) begin errors++; $display("FAIL rdwe_no_write got %0d write cycles exp 0", bad); end
    tests++; if (ddram_busy !== 1'b0) begin errors++; $display("FAIL rdwe_idle got busy=%b exp 0", ddram_busy); end
  endtask

  task automatic test_burst0();
    ddram_rd = 1'b1; ddram_addr = 29'h7; ddram_burstcnt = 8'd0;
    step();
    ddram_rd = 1'b0;
    tests++; if (avl_size !== 8'd1) begin errors++; $display("FAIL b0_size got %0d exp 1", avl_size); end
    avl_ready = 1'b1;
    step();
    avl_ready = 1'b0; avl_rdata_valid = 1'b1; avl_rdata = 64'h5A;
    step();
    avl_rdata_valid = 1'b0;
    tests++; if (ddram_dout_ready !== 1'b1 || ddram_dout !== 64'h5A) begin
      errors++; $display("FAIL b0_beat got rdy=%b data=%h exp 1 5a", ddram_dout_ready, ddram_dout); end
    tests++; if (ddram_busy !== 1'b0) begin errors++; $display("FAIL b0_idle got busy=%b exp 0", ddram_busy); end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    ddram_rd = 1'b1; ddram_addr = 29'h200; ddram_burstcnt = 8'd8;
    step();
    ddram_rd = 1'b0; avl_ready = 1'b1;
    step();
    avl_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      avl_rdata_valid = 1'b1; avl_rdata = 64'h300 + 64'(i);
      step();
    end
    tests++; if (ddram_dout_ready !== 1'b1 || ddram_dout !== 64'h301) begin
      errors++; $display("FAIL rm_pre got rdy=%b data=%h exp 1 301", ddram_dout_ready, ddram_dout); end
    rst_n = 1'b0;
    #1;
    tests++; if ({avl_read_req, avl_write_req, avl_burstbegin, ddram_dout_ready} !== 4'b0 || ddram_busy !== 1'b1) begin
      errors++; $display("FAIL rm_strobes got %b busy=%b exp 0000 1", {avl_read_req, avl_write_req, avl_burstbegin, ddram_dout_ready}, ddram_busy); end
    tests++; if ({avl_addr, avl_size, ddram_dout} !== '0) begin
      errors++; $display("FAIL rm_data got %h exp 0", {avl_addr, avl_size, ddram_dout}); end
    step();
    rst_n = 1'b1;
    #1;
    tests++; if (ddram_busy !== 1'b1) begin errors++; $display("FAIL rm_init got busy=%b exp 1", ddram_busy); end
    for (int i = 0; i < 4; i++) begin
      step();
      if (ddram_dout_ready !== 1'b0 || avl_read_req !== 1'b0 || avl_burstbegin !== 1'b0) bad++;
    end
    avl_rdata_valid = 1'b0;
    tests++; if (bad != 0) begin errors++; $display("FAIL rm_quiet got %0d active cycles exp 0", bad); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_read();
    test_write();
    test_rd_we();
    test_burst0();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
